// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer for the serial-to-parallel loader and 512-point FFT core
module fft_frame_ctrl #(
    parameter int TOTAL_SIZE  = 512,
    parameter int P_SIZE      = 16,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16,
    localparam int SMP_W      = $clog2(TOTAL_SIZE),
    localparam int BLK_W      = $clog2(TOTAL_SIZE / P_SIZE),
    localparam int TO_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             cont_mode,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             smp_en,
    output logic [SMP_W-1:0] smp_cnt,
    output logic [BLK_W-1:0] blk_idx,
    input  logic             fft_done,
    output logic             frame_valid,
    input  logic             frame_ready,
    output logic             busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             timeout_err,
    output logic             seq_err,
    input  logic             clr_err,
    output logic [1:0]       state
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] LOAD     = 2'd1;
    localparam logic [1:0] WAIT_FFT = 2'd2;
    localparam logic [1:0] HOLD     = 2'd3;

    logic [1:0]      state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            smp_last;
    logic            to_expire;
    logic            to_err_set;
    logic            seq_err_set;

    assign smp_en  = s_valid & s_ready;
    // Sample counter is a power of two, so the top bits are the block index.
    assign blk_idx = smp_cnt[SMP_W-1 -: BLK_W];

    always_comb begin
        state_nxt   = state;
        smp_last    = smp_en && (smp_cnt == SMP_W'(TOTAL_SIZE - 1));
        to_expire   = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
        to_err_set  = 1'b0;
        seq_err_set = fft_done && (state != WAIT_FFT);
        case (state)
            IDLE: begin
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                if (smp_last) state_nxt = WAIT_FFT;
            end
            WAIT_FFT: begin
                // A completion on the expiry cycle still counts as done.
                if (fft_done) begin
                    state_nxt = HOLD;
                end else if (to_expire) begin
                    state_nxt  = IDLE;
                    to_err_set = 1'b1;
                end
            end
            HOLD: begin
                if (frame_ready) state_nxt = cont_mode ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state       <= IDLE;
            s_ready     <= 1'b0;
            smp_cnt     <= '0;
            frame_valid <= 1'b0;
            busy        <= 1'b0;
            frame_cnt   <= '0;
            timeout_err <= 1'b0;
            seq_err     <= 1'b0;
            to_cnt      <= '0;
        end else begin
            state       <= state_nxt;
            s_ready     <= (state_nxt == LOAD);
            busy        <= (state_nxt != IDLE);
            frame_valid <= (state_nxt == HOLD);
            if (smp_en) smp_cnt <= smp_cnt + SMP_W'(1);
            to_cnt <= (state == WAIT_FFT && state_nxt == WAIT_FFT) ? to_cnt + TO_W'(1) : '0;
            if (state == HOLD && frame_ready) frame_cnt <= frame_cnt + CNT_W'(1);
            // New error events take priority over a simultaneous clear.
            timeout_err <= to_err_set  | (timeout_err & ~clr_err);
            seq_err     <= seq_err_set | (seq_err & ~clr_err);
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed vector and sequence bench for fft_frame_ctrl
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        cont_mode = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        smp_en;
    logic [8:0]  smp_cnt;
    logic [4:0]  blk_idx;
    logic        fft_done = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;
    logic        timeout_err;
    logic        seq_err;
    logic        clr_err = 1'b0;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;

    fft_frame_ctrl #(.TOTAL_SIZE(512), .P_SIZE(16), .TIMEOUT_CYC(64), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .start(start), .cont_mode(cont_mode),
        .s_valid(s_valid), .s_ready(s_ready), .smp_en(smp_en), .smp_cnt(smp_cnt),
        .blk_idx(blk_idx), .fft_done(fft_done), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .busy(busy), .frame_cnt(frame_cnt),
        .timeout_err(timeout_err), .seq_err(seq_err), .clr_err(clr_err), .state(state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (smp_en === 1'b1) en_cnt <= en_cnt + 1;

    typedef struct {
        logic       rst;
        logic       start;
        logic       done;
        logic       sv;
        logic       clr;
        logic [1:0] st;
        logic       srdy;
        logic [8:0] cnt;
        logic       busy;
        logic       serr;
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Streams n accepted samples, checking index, block and strobe on every accept.
    task automatic stream(input int n, input int base, output int bad);
        int idx;
        bad = 0;
        s_valid = 1'b1;
        #1;
        for (int k = 0; k < n; k++) begin
            idx = (base + k) % 512;
            if (smp_en !== 1'b1 || smp_cnt !== idx[8:0] || blk_idx !== idx[8:4]) bad++;
            tick();
        end
    endtask

    initial begin
        int bad;
        int e0;
        int accepted;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 9'd0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 9'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 9'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 9'd1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 9'd2, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 9'd3, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 9'd0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 9'd0, 1'b1, 1'b0};

        for (int i = 0; i < 12; i++) begin
            rstn = vecs[i].rst; start = vecs[i].start; fft_done = vecs[i].done;
            s_valid = vecs[i].sv; clr_err = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i),
                  32'({state, s_ready, smp_cnt, busy, seq_err}),
                  32'({vecs[i].st, vecs[i].srdy, vecs[i].cnt, vecs[i].busy, vecs[i].serr}));
        end
        rstn = 1'b0; start = 1'b0; fft_done = 1'b0; s_valid = 1'b0; clr_err = 1'b0;

        // Single-shot frame, completion 40 cycles after the last accept.
        rstn = 1'b1; tick(); rstn = 1'b0;
        frame_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        e0 = en_cnt;
        stream(512, 0, bad);
        check("a_stream", 32'(bad), 32'd0);
        check("a_wait_entry", 32'({state, s_ready}), 32'({2'd2, 1'b0}));
        bad = 0;
        for (int j = 0; j < 39; j++) begin
            tick();
            if (frame_valid !== 1'b0 || state !== 2'd2) bad++;
        end
        check("a_accepts", 32'(en_cnt - e0), 32'd512);
        check("a_wait_hold", 32'(bad), 32'd0);
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        check("a_hold", 32'({state, frame_valid}), 32'({2'd3, 1'b1}));
        tick();
        check("a_done", 32'({state, frame_valid, busy, frame_cnt}), 32'({2'd0, 1'b0, 1'b0, 16'd1}));

        // Alternating s_valid, then let the frame time out.
        rstn = 1'b1; tick(); rstn = 1'b0;
        frame_ready = 1'b0; s_valid = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        e0 = en_cnt; accepted = 0; bad = 0;
        for (int i = 0; i < 1023; i++) begin
            s_valid = (i % 2 == 0);
            tick();
            if (i % 2 == 0) accepted++;
            if (i < 1022 && (state !== 2'd1 || smp_cnt !== 9'(accepted))) bad++;
        end
        s_valid = 1'b0;
        check("b_toggle", 32'(bad), 32'd0);
        check("b_accepts", 32'(en_cnt - e0), 32'd512);
        check("b_wait", 32'({state, smp_cnt}), 32'({2'd2, 9'd0}));
        bad = 0;
        for (int j = 1; j < 64; j++) begin
            tick();
            if (timeout_err !== 1'b0 || state !== 2'd2 || frame_valid !== 1'b0) bad++;
        end
        check("d_pre_timeout", 32'(bad), 32'd0);
        tick();
        check("d_timeout", 32'({timeout_err, state, frame_valid}), 32'({1'b1, 2'd0, 1'b0}));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        check("d_clr", 32'(timeout_err), 32'd0);

        // Continuous mode with a reader that stalls for 100 cycles.
        rstn = 1'b1; tick(); rstn = 1'b0;
        cont_mode = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        stream(512, 0, bad);
        check("c_stream", 32'(bad), 32'd0);
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        check("c_hold", 32'({state, frame_valid}), 32'({2'd3, 1'b1}));
        bad = 0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (frame_valid !== 1'b1 || s_ready !== 1'b0 || state !== 2'd3 || smp_en !== 1'b0) bad++;
        end
        check("c_stall", 32'(bad), 32'd0);
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        check("c_rearm", 32'({state, s_ready, frame_valid, smp_en, frame_cnt}),
              32'({2'd1, 1'b1, 1'b0, 1'b1, 16'd1}));
        tick();
        check("c_first", 32'(smp_cnt), 32'd1);
        cont_mode = 1'b0;

        // Out-of-sequence fft_done during LOAD, with a colliding clr_err.
        rstn = 1'b1; tick(); rstn = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        e0 = en_cnt;
        stream(100, 0, bad);
        fft_done = 1'b1; clr_err = 1'b1; tick(); fft_done = 1'b0; clr_err = 1'b0;
        check("e_seq_err", 32'({seq_err, smp_cnt, state}), 32'({1'b1, 9'd101, 2'd1}));
        accepted = bad;
        stream(411, 101, bad);
        check("e_stream", 32'(bad + accepted), 32'd0);
        check("e_accepts", 32'(en_cnt - e0), 32'd512);
        check("e_wait", 32'(state), 32'd2);
        fft_done = 1'b1; tick(); fft_done = 1'b0;
        frame_ready = 1'b1; tick(); frame_ready = 1'b0;
        check("e_done", 32'({state, frame_cnt, seq_err}), 32'({2'd0, 16'd1, 1'b1}));

        // Reset in the middle of a frame, then a clean frame.
        start = 1'b1; tick(); start = 1'b0;
        stream(300, 0, bad);
        check("f_partial", 32'({bad[7:0], smp_cnt}), 32'({8'd0, 9'd300}));
        rstn = 1'b1; tick(); rstn = 1'b0;
        check("f_reset", 32'({state, s_ready, smp_cnt, frame_valid, busy, frame_cnt, timeout_err, seq_err, smp_en}), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        e0 = en_cnt;
        stream(512, 0, bad);
        check("f_stream", 32'(bad), 32'd0);
        check("f_accepts", 32'(en_cnt - e0), 32'd512);
        check("f_wait", 32'({state, frame_valid}), 32'({2'd2, 1'b0}));
        s_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
